aes_key_schedule_ctrl: RTL and testbench

Sequencer for AES-128 key expansion. It accepts a 128-bit cipher key and drives one instance of the combinational round-key block (key_maker) once per clock for rounds 1..10. Each result is stored in an 11-entry round-key buffer (slot 0 is the cipher key). The cipher/decipher round pipeline then reads keys by round index through a registered read port.

---
 rtl/aes_key_schedule_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_aes_key_schedule_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key expansion sequencer: one combinational round-key step per clock,
// results kept in an 11-entry round-key buffer behind a registered read port.

module aes_key_maker (
    input  logic [127:0] previous_key,
    input  logic [3:0]   round,
    output logic [127:0] round_key
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        logic [7:0] b;
        sq  = gf_mul(x, x);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        b = acc;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    logic [31:0] w0, w1, w2, w3, rot, temp, n0, n1, n2, n3;

    always_comb begin
        w0   = previous_key[127:96];
        w1   = previous_key[95:64];
        w2   = previous_key[63:32];
        w3   = previous_key[31:0];
        rot  = {w3[23:0], w3[31:24]};
        temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
               ^ {rcon(round), 24'h000000};
        n0   = w0 ^ temp;
        n1   = n0 ^ w1;
        n2   = n1 ^ w2;
        n3   = n2 ^ w3;
        round_key = {n0, n1, n2, n3};
    end

endmodule

module aes_key_schedule_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [0:127] cipher_key,
    input  logic         flush,
    output logic         busy,
    output logic         keys_valid,
    output logic         done,
    input  logic         rd_en,
    input  logic [0:3]   rd_round,
    output logic [0:127] rd_key,
    output logic         rd_valid,
    output logic         rd_err
);

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_READY} state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t         state_q, state_d;
    logic [3:0]     round_cnt_q, round_cnt_d;
    logic [127:0]   prev_key_q, prev_key_d;
    logic [127:0]   slot_q [0:NUM_ROUNDS];
    logic [127:0]   slot_d [0:NUM_ROUNDS];
    logic           keys_valid_q, keys_valid_d;
    logic           done_q, done_d;
    logic [127:0]   rd_key_q, rd_key_d;
    logic           rd_valid_q, rd_valid_d;
    logic           rd_err_q, rd_err_d;
    logic [127:0]   round_key;
    logic [127:0]   key_in;
    logic [3:0]     rd_idx;

    assign key_in = cipher_key;
    assign rd_idx = rd_round;

    aes_key_maker u_key_maker (
        .previous_key (prev_key_q),
        .round        (round_cnt_q),
        .round_key    (round_key)
    );

    assign key_ready  = (state_q != S_EXPAND);
    assign busy       = (state_q == S_EXPAND);
    assign keys_valid = keys_valid_q;
    assign done       = done_q;
    assign rd_key     = rd_key_q;
    assign rd_valid   = rd_valid_q;
    assign rd_err     = rd_err_q;

    always_comb begin
        state_d      = state_q;
        round_cnt_d  = round_cnt_q;
        prev_key_d   = prev_key_q;
        slot_d       = slot_q;
        keys_valid_d = keys_valid_q;
        done_d       = 1'b0;
        rd_key_d     = rd_key_q;
        rd_valid_d   = 1'b0;
        rd_err_d     = 1'b0;

        // flush wins over both key acceptance and the terminal expansion step
        if (flush) begin
            state_d      = S_IDLE;
            keys_valid_d = 1'b0;
            round_cnt_d  = 4'd0;
        end else begin
            case (state_q)
                S_IDLE, S_READY: begin
                    if (key_valid) begin
                        slot_d[0]    = key_in;
                        prev_key_d   = key_in;
                        round_cnt_d  = 4'd1;
                        keys_valid_d = 1'b0;
                        state_d      = S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    slot_d[round_cnt_q] = round_key;
                    prev_key_d          = round_key;
                    if (round_cnt_q == LAST_ROUND) begin
                        state_d      = S_READY;
                        keys_valid_d = 1'b1;
                        done_d       = 1'b1;
                    end else begin
                        round_cnt_d = round_cnt_q + 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Reads use the pre-edge buffer and keys_valid, so a read on a rekey edge sees old data
        if (rd_en) begin
            if (keys_valid_q && (rd_idx <= LAST_ROUND)) begin
                rd_key_d   = slot_q[rd_idx];
                rd_valid_d = 1'b1;
            end else begin
                rd_key_d = '0;
                rd_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            round_cnt_q  <= 4'd0;
            prev_key_q   <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) slot_q[i] <= '0;
            keys_valid_q <= 1'b0;
            done_q       <= 1'b0;
            rd_key_q     <= '0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_cnt_q  <= round_cnt_d;
            prev_key_q   <= prev_key_d;
            slot_q       <= slot_d;
            keys_valid_q <= keys_valid_d;
            done_q       <= done_d;
            rd_key_q     <= rd_key_d;
            rd_valid_q   <= rd_valid_d;
            rd_err_q     <= rd_err_d;
        end
    end

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Self-checking bench for aes_key_schedule_ctrl: cycle model built from the
// FIPS-197 expansion rules plus directed literal checks.

module tb_aes_key_schedule_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] cipher_key;
    logic         flush;
    logic         busy;
    logic         keys_valid;
    logic         done;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
    logic         rd_valid;
    logic         rd_err;

    int total = 0;
    int bad = 0;

    localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes_key_schedule_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .cipher_key (cipher_key),
        .flush      (flush),
        .busy       (busy),
        .keys_valid (keys_valid),
        .done       (done),
        .rd_en      (rd_en),
        .rd_round   (rd_round),
        .rd_key     (rd_key),
        .rd_valid   (rd_valid),
        .rd_err     (rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    logic [7:0] sbox_t [0:255];
    logic [7:0] rcon_t [1:10];

    function automatic int gmul(input int a, input int b);
        int r = 0;
        while (b != 0) begin
            if ((b & 1) != 0) r = r ^ a;
            a = a << 1;
            if ((a & 256) != 0) a = a ^ 'h11b;
            b = b >> 1;
        end
        return r;
    endfunction

    task automatic build_tables();
        int inv;
        int c;
        logic [7:0] b, s, cc;
        cc = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) inv = y;
            b = inv[7:0];
            for (int i = 0; i < 8; i++)
                s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ cc[i];
            sbox_t[x] = s;
        end
        c = 1;
        for (int r = 1; r <= 10; r++) begin
            rcon_t[r] = c[7:0];
            c = gmul(c, 2);
        end
    endtask

    task automatic expand_key(input logic [127:0] k, output logic [127:0] ks [0:10]);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rcon_t[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- cycle model ----------------
    int           m_rem;          // expansion edges still to come (0 = not expanding)
    logic         m_kv;
    logic         m_done;
    logic [127:0] m_sched [0:10]; // schedule visible to reads
    logic [127:0] m_pend [0:10];  // schedule under construction
    logic [127:0] e_rd_key;
    logic         e_rd_valid;
    logic         e_rd_err;
    logic         model_on = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem = 0; m_kv = 1'b0; m_done = 1'b0;
            for (int i = 0; i <= 10; i++) m_sched[i] = '0;
            e_rd_key = '0; e_rd_valid = 1'b0; e_rd_err = 1'b0;
        end else begin
            e_rd_valid = 1'b0;
            e_rd_err   = 1'b0;
            if (rd_en) begin
                if (m_kv && rd_round <= 4'd10) begin
                    e_rd_key = m_sched[rd_round];
                    e_rd_valid = 1'b1;
                end else begin
                    e_rd_key = '0;
                    e_rd_err = 1'b1;
                end
            end
            m_done = 1'b0;
            if (flush) begin
                m_rem = 0;
                m_kv = 1'b0;
            end else if (m_rem == 0) begin
                if (key_valid) begin
                    expand_key(cipher_key, m_pend);
                    m_rem = 10;
                    m_kv = 1'b0;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_kv = 1'b1;
                    m_done = 1'b1;
                    m_sched = m_pend;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("key_ready", 128'(key_ready), 128'(m_rem == 0));
            chk("busy", 128'(busy), 128'(m_rem != 0));
            chk("keys_valid", 128'(keys_valid), 128'(m_kv));
            chk("done", 128'(done), 128'(m_done));
            chk("rd_valid", 128'(rd_valid), 128'(e_rd_valid));
            chk("rd_err", 128'(rd_err), 128'(e_rd_err));
            chk("rd_key", rd_key, e_rd_key);
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string name, input int r, input logic [127:0] exp);
        rd_en = 1'b1;
        rd_round = 4'(r);
        step();
        rd_en = 1'b0;
        chk(name, rd_key, exp);
        chk({name, "_valid"}, 128'(rd_valid), 128'(1));
    endtask

    task automatic accept_key(input logic [127:0] k);
        key_valid = 1'b1;
        cipher_key = k;
        step();
        key_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_edges);
        int c = 0;
        while (!done && c < 40) begin
            step();
            c++;
        end
        chk(name, 128'(c), 128'(exp_edges));
    endtask

    logic [127:0] ks [0:10];
    logic [127:0] rnd_key;
    int           cnt;
    logic         saw_done;

    initial begin
        key_valid = 1'b0; cipher_key = '0; flush = 1'b0; rd_en = 1'b0; rd_round = '0;

        build_tables();
        chk("sbox_00", 128'(sbox_t[8'h00]), 128'h63);
        chk("sbox_01", 128'(sbox_t[8'h01]), 128'h7c);
        chk("sbox_53", 128'(sbox_t[8'h53]), 128'hed);
        chk("rcon_10", 128'(rcon_t[10]), 128'h36);
        expand_key(KEY_A, ks);
        chk("model_a_r1", ks[1], A_R1);
        chk("model_a_r10", ks[10], A_R10);
        expand_key(KEY_B, ks);
        chk("model_b_r10", ks[10], B_R10);

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_key_ready", 128'(key_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_keys_valid", 128'(keys_valid), 128'(0));
        chk("rst_rd_key", rd_key, 128'h0);
        model_on = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        step();

        // FIPS-197 key: done after ten expansion edges, then directed reads
        accept_key(KEY_A);
        wait_done("accept_to_done", 10);
        chk("a_keys_valid", 128'(keys_valid), 128'(1));
        read_check("a_slot1", 1, A_R1);
        read_check("a_slot10", 10, A_R10);
        read_check("a_slot0", 0, KEY_A);

        // Out-of-range read in READY
        rd_en = 1'b1; rd_round = 4'd11;
        step();
        rd_en = 1'b0;
        chk("oor_err", 128'(rd_err), 128'(1));
        chk("oor_valid", 128'(rd_valid), 128'(0));
        chk("oor_key", rd_key, 128'h0);
        step();
        chk("oor_err_pulse", 128'(rd_err), 128'(0));

        // Read while busy, then flush sampled at accept+5
        accept_key(KEY_A);
        rd_en = 1'b1; rd_round = 4'd3;
        step();
        rd_en = 1'b0;
        chk("busy_read_err", 128'(rd_err), 128'(1));
        repeat (3) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", 128'(busy), 128'(0));
        chk("flush_keys_valid", 128'(keys_valid), 128'(0));
        chk("flush_key_ready", 128'(key_ready), 128'(1));
        saw_done = 1'b0;
        repeat (12) begin
            step();
            saw_done = saw_done | done;
        end
        chk("flush_no_done", 128'(saw_done), 128'(0));

        rnd_key = {$urandom, $urandom, $urandom, $urandom};
        expand_key(rnd_key, ks);
        accept_key(rnd_key);
        wait_done("post_flush_done", 10);
        for (int r = 0; r <= 10; r++) read_check($sformatf("rnd_slot%0d", r), r, ks[r]);

        // Rekey in READY with a same-edge slot-0 read that must see the old key
        key_valid = 1'b1; cipher_key = KEY_B; rd_en = 1'b1; rd_round = 4'd0;
        step();
        key_valid = 1'b0; rd_en = 1'b0;
        chk("rekey_old_slot0", rd_key, rnd_key);
        chk("rekey_kv_drop", 128'(keys_valid), 128'(0));
        cnt = 0;
        while (!key_ready && cnt < 30) begin
            cnt++;
            step();
        end
        chk("rekey_ready_low", 128'(cnt), 128'(10));
        read_check("b_slot10", 10, B_R10);

        // key_valid held during EXPAND with another key is ignored
        accept_key(KEY_A);
        key_valid = 1'b1; cipher_key = KEY_B;
        repeat (10) step();
        key_valid = 1'b0;
        chk("hold_keys_valid", 128'(keys_valid), 128'(1));
        read_check("hold_slot10", 10, A_R10);
        read_check("hold_slot1", 1, A_R1);

        // Asynchronous reset mid-expansion
        accept_key(KEY_B);
        repeat (3) step();
        #3 rst_n = 1'b0;
        #1;
        chk("areset_busy", 128'(busy), 128'(0));
        chk("areset_key_ready", 128'(key_ready), 128'(1));
        chk("areset_keys_valid", 128'(keys_valid), 128'(0));
        chk("areset_rd_key", rd_key, 128'h0);
        #3 rst_n = 1'b1;
        step();
        chk("areset_release_ready", 128'(key_ready), 128'(1));

        // Random traffic against the cycle model
        for (int i = 0; i < 800; i++) begin
            key_valid  = ($urandom_range(0, 3) == 0);
            cipher_key = {$urandom, $urandom, $urandom, $urandom};
            flush      = ($urandom_range(0, 39) == 0);
            rd_en      = ($urandom_range(0, 1) == 1);
            rd_round   = 4'($urandom_range(0, 15));
            step();
        end
        key_valid = 1'b0; flush = 1'b0; rd_en = 1'b0;
        repeat (15) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
